// File: rtl/tea_pkg.sv
// Shared TEA constants, FSM encoding and key-word slice positions.
// Used by both the encryptor and the decryptor.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA  = 32'h9E3779B9;
    localparam int          TEA_ROUNDS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } tea_state_e;

    // Most-significant bit of each 32-bit key word inside the 128-bit key.
    localparam int K0_MSB = 127;
    localparam int K1_MSB = 95;
    localparam int K2_MSB = 63;
    localparam int K3_MSB = 31;

endpackage

// File: rtl/tea_feistel.sv
// TEA half-round mixing function: ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb), all mod 2^32.
// Purely combinational.
module tea_feistel (
    input  logic [31:0] v,
    input  logic [31:0] sum,
    input  logic [31:0] ka,
    input  logic [31:0] kb,
    output logic [31:0] f
);

    assign f = ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);

endmodule

// File: rtl/tea_en_core.sv
// Iterative TEA encryptor: one full round per clock.
// Ciphertext is held on data until the next job completes.
//
// state   | meaning
// IDLE    | waiting for ready
// LOAD    | capture plaintext, key and delta; clear sum and round counter
// RUN     | one full TEA round per cycle
// DONE    | done pulse for one cycle, then back to IDLE
module tea_en_core
    import tea_pkg::*;
#(
    parameter int ROUNDS = TEA_ROUNDS,
    parameter int CNT_W  = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   d1_y,
    input  logic [31:0]   d2_z,
    input  logic [127:0]  key,
    input  logic [31:0]   delta,
    input  logic          ready,
    output logic          done,
    output logic          work_in_progress,
    output logic [63:0]   data
);

    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

    tea_state_e         state_q, state_d;
    logic [31:0]        y_q, y_d;
    logic [31:0]        z_q, z_d;
    logic [31:0]        sum_q, sum_d;
    logic [31:0]        delta_q, delta_d;
    logic [127:0]       key_q, key_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        data_q, data_d;

    logic [31:0]        sum_nxt;
    logic [31:0]        f_y, f_z;
    logic [31:0]        y_nxt, z_nxt;

    assign sum_nxt = sum_q + delta_q;

    tea_feistel u_mix_y (
        .v   (z_q),
        .sum (sum_nxt),
        .ka  (key_q[K0_MSB -: 32]),
        .kb  (key_q[K1_MSB -: 32]),
        .f   (f_y)
    );

    assign y_nxt = y_q + f_y;

    // The z-half consumes the freshly updated y within the same cycle.
    tea_feistel u_mix_z (
        .v   (y_nxt),
        .sum (sum_nxt),
        .ka  (key_q[K2_MSB -: 32]),
        .kb  (key_q[K3_MSB -: 32]),
        .f   (f_z)
    );

    assign z_nxt = z_q + f_z;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        z_d     = z_q;
        sum_d   = sum_q;
        delta_d = delta_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                y_d     = d1_y;
                z_d     = d2_z;
                key_d   = key;
                delta_d = delta;
                sum_d   = '0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                y_d   = y_nxt;
                z_d   = z_nxt;
                sum_d = sum_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_RND) begin
                    data_d  = {y_nxt, z_nxt};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            z_q     <= '0;
            sum_q   <= '0;
            delta_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            z_q     <= z_d;
            sum_q   <= sum_d;
            delta_q <= delta_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign done             = (state_q == ST_DONE);
    assign work_in_progress = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign data             = data_q;

endmodule

// File: tb/tb_tea_en_core.sv
// Self-checking bench for tea_en_core: directed jobs feed a scoreboard queue,
// a negedge monitor pops and compares on every done pulse.
module tb_tea_en_core;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   d1_y, d2_z, delta;
    logic [127:0]  key;
    logic          ready;
    logic          done, wip;
    logic [63:0]   data;

    localparam logic [31:0]  STD_DELTA = 32'h9E3779B9;
    localparam logic [63:0]  T1_CT     = 64'h41EA3A0A_94BAA940;
    localparam logic [127:0] T2_KEY    = 128'h95b3a17446cf51e1d8c4f6b493a71922;
    localparam logic [127:0] T2B_KEY   = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    tea_en_core dut (
        .clk              (clk),
        .rst              (rst),
        .d1_y             (d1_y),
        .d2_z             (d2_z),
        .key              (key),
        .delta            (delta),
        .ready            (ready),
        .done             (done),
        .work_in_progress (wip),
        .data             (data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0]  exp;
        bit           rt;
        logic [127:0] k;
        logic [31:0]  dl;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   done_cnt = 0;
    int   done_cyc[$];
    int   wip_low_cyc[$];
    int   kedge;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Independent reference: standard TEA decryption.
    function automatic logic [63:0] tea_dec(input logic [63:0] c, input logic [127:0] k,
                                            input logic [31:0] dl);
        logic [31:0] y, z, s, k0, k1, k2, k3;
        y  = c[63:32];
        z  = c[31:0];
        s  = dl << 5;
        k0 = k[127:96];
        k1 = k[95:64];
        k2 = k[63:32];
        k3 = k[31:0];
        for (int i = 0; i < 32; i++) begin
            z = z - ((((y << 4) + k2) ^ (y + s)) ^ ((y >> 5) + k3));
            y = y - ((((z << 4) + k0) ^ (z + s)) ^ ((z >> 5) + k1));
            s = s - dl;
        end
        return {y, z};
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1 && wip === 1'b0) wip_low_cyc.push_back(cyc);
        if (rst === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_cnt++;
            done_cyc.push_back(cyc);
            check_int("done_wip_low", int'(wip), 0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                if (e.rt) check64("roundtrip", tea_dec(data, e.k, e.dl), e.exp);
                else      check64("ciphertext", data, e.exp);
                if (e.due >= 0) check_int("latency", cyc, e.due);
            end
        end
    end

    task automatic push_exp(input logic [63:0] exp, input bit rt, input logic [127:0] k,
                            input logic [31:0] dl, input int due);
        exp_t e;
        e.exp = exp; e.rt = rt; e.k = k; e.dl = dl; e.due = due;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(wip === 1'b0 && done === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_int("done_count", done_cnt, target);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the LOAD
    // cycle with ready low and kedge = index of the edge that sampled ready.
    task automatic start(input logic [31:0] y, input logic [31:0] z,
                         input logic [127:0] k, input logic [31:0] dl);
        d1_y  = y;
        d2_z  = z;
        key   = k;
        delta = dl;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        kedge = cyc;
    endtask

    initial begin
        int k0;
        int lows;
        rst = 1'b0; ready = 1'b0;
        d1_y = '0; d2_z = '0; key = '0; delta = '0;
        repeat (3) @(negedge clk);
        check_int("rst_done", int'(done), 0);
        check_int("rst_wip", int'(wip), 0);
        check64("rst_data", data, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // T1: all-zero known vector, exact latency.
        wait_idle();
        start(32'h0, 32'h0, 128'h0, STD_DELTA);
        push_exp(T1_CT, 1'b0, '0, '0, kedge + 33);
        wait_dones(1, 60);

        // T2: round trip through an independent decryptor.
        wait_idle();
        start(32'h01234567, 32'h89ABCDEF, T2_KEY, STD_DELTA);
        push_exp(64'h01234567_89ABCDEF, 1'b1, T2_KEY, STD_DELTA, kedge + 33);
        wait_dones(2, 60);
        wait_idle();
        start(32'hDEADBEEF, 32'hCAFEBABE, T2B_KEY, 32'h12345678);
        push_exp(64'hDEADBEEF_CAFEBABE, 1'b1, T2B_KEY, 32'h12345678, -1);
        wait_dones(3, 60);

        // T3: async reset mid-RUN aborts the job silently.
        wait_idle();
        start(32'h0, 32'h0, 128'h0, STD_DELTA);
        repeat (11) @(negedge clk);
        rst = 1'b0;
        #1;
        check_int("abort_done", int'(done), 0);
        check_int("abort_wip", int'(wip), 0);
        check64("abort_data", data, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_int("abort_no_done", done_cnt, 3);
        wait_idle();
        start(32'h0, 32'h0, 128'h0, STD_DELTA);
        push_exp(T1_CT, 1'b0, '0, '0, kedge + 33);
        wait_dones(4, 60);

        // T4: ready re-pulsed with different operands during RUN is ignored.
        wait_idle();
        start(32'h0, 32'h0, 128'h0, STD_DELTA);
        push_exp(T1_CT, 1'b0, '0, '0, kedge + 33);
        repeat (5) @(negedge clk);
        d1_y = 32'h55AA55AA; key = T2_KEY; ready = 1'b1;
        repeat (3) @(negedge clk);
        ready = 1'b0;
        check64("data_hold_run", data, T1_CT);
        wait_dones(5, 60);
        repeat (40) @(negedge clk);
        check_int("busy_single_done", done_cnt, 5);

        // T6: operands change right after LOAD; result must not move.
        wait_idle();
        start(32'h0, 32'h0, 128'h0, STD_DELTA);
        push_exp(T1_CT, 1'b0, '0, '0, kedge + 33);
        @(negedge clk);
        d1_y = 32'hFFFFFFFF; d2_z = 32'h13579BDF; key = T2B_KEY; delta = 32'h0BADF00D;
        wait_dones(6, 60);

        // T5: ready held high -> three back-to-back jobs.
        wait_idle();
        d1_y = '0; d2_z = '0; key = '0; delta = STD_DELTA;
        k0 = cyc + 1;
        ready = 1'b1;
        for (int j = 0; j < 3; j++) push_exp(T1_CT, 1'b0, '0, '0, k0 + 33 + 35 * j);
        while (cyc < k0 + 70) @(negedge clk);
        ready = 1'b0;
        wait_dones(9, 60);
        if (done_cyc.size() >= 9) begin
            check_int("b2b_gap1", done_cyc[7] - done_cyc[6], 35);
            check_int("b2b_gap2", done_cyc[8] - done_cyc[7], 35);
            lows = 0;
            foreach (wip_low_cyc[i])
                if (wip_low_cyc[i] >= done_cyc[6] && wip_low_cyc[i] <= done_cyc[8]) lows++;
            check_int("b2b_wip_low_cycles", lows, 5);
        end else begin
            checks++;
            failures++;
            $display("FAIL b2b_pulses: got %0d done pulses expected 9", done_cyc.size());
        end

        repeat (10) @(negedge clk);
        check_int("scoreboard_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
